// File: rtl/calc_disp_pkg.sv
// Shared constants and helpers for the calculator display path.
package calc_disp_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [7:0] AN_OFF    = 8'hFF;

   localparam logic [1:0] ST_OFF   = 2'd0;
   localparam logic [1:0] ST_GUARD = 2'd1;
   localparam logic [1:0] ST_ON    = 2'd2;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
module seven_segment_decoder (
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h7F;
      case (hex)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed common-anode display scanner with frame-aligned value updates,
// leading-zero blanking and a dark guard interval at the start of each slot.
module seven_seg_scan_ctrl
   import calc_disp_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 500
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              enable,
   input  logic                              load,
   input  logic [4*NUM_DIGITS-1:0]           value,
   input  logic [NUM_DIGITS-1:0]             dp_mask,
   input  logic                              lz_en,
   output logic [NUM_DIGITS-1:0]             an,
   output logic [6:0]                        seg,
   output logic                              dp,
   output logic [idx_w(NUM_DIGITS)-1:0]      digit_idx,
   output logic                              frame_done
);

   localparam int IW = idx_w(NUM_DIGITS);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0]         CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0]         CNT_GUARD = CW'(GUARD_CYCLES);
   localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_DARK   = AN_OFF[NUM_DIGITS-1:0];
   localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] value;
      logic [NUM_DIGITS-1:0]   dp_mask;
      logic                    lz_en;
   } disp_t;

   logic [1:0]            state, state_nxt;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic [IW-1:0]         idx_nxt;
   disp_t                 pend, pend_nxt, act, act_nxt, din;
   logic                  pend_v, pend_v_nxt;
   logic                  boundary;
   logic [NUM_DIGITS-1:0] blank;
   logic [3:0]            nib;
   logic [6:0]            dec_seg;
   logic [NUM_DIGITS-1:0] an_nxt;
   logic [6:0]            seg_nxt;
   logic                  dp_nxt, fd_nxt;

   // Slot sequencing: counters are computed ahead so outputs register in step with state.
   always_comb begin
      boundary  = (state != ST_OFF) && (cnt == CNT_LAST) && (digit_idx == IDX_LAST);
      cnt_nxt   = '0;
      idx_nxt   = '0;
      state_nxt = ST_OFF;
      if (enable) begin
         if (state != ST_OFF) begin
            if (cnt == CNT_LAST) begin
               idx_nxt = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
               idx_nxt = digit_idx;
            end
         end
         state_nxt = (cnt_nxt >= CNT_GUARD) ? ST_ON : ST_GUARD;
      end
   end

   // While dark there is nothing to tear, so a load lands in active at once.
   always_comb begin
      din        = '{value: value, dp_mask: dp_mask, lz_en: lz_en};
      act_nxt    = act;
      pend_nxt   = pend;
      pend_v_nxt = pend_v;
      if (load && (state == ST_OFF || boundary)) begin
         act_nxt    = din;
         pend_v_nxt = 1'b0;
      end else if (load) begin
         pend_nxt   = din;
         pend_v_nxt = 1'b1;
      end else if (boundary && pend_v) begin
         act_nxt    = pend;
         pend_v_nxt = 1'b0;
      end
   end

   always_comb begin
      blank = '0;
      for (int k = 1; k < NUM_DIGITS; k++)
         blank[k] = act_nxt.lz_en && ((act_nxt.value >> (4 * k)) == '0);
      nib = act_nxt.value[4*idx_nxt +: 4];
   end

   seven_segment_decoder u_dec (
      .hex (nib),
      .seg (dec_seg)
   );

   always_comb begin
      an_nxt  = AN_DARK;
      seg_nxt = SEG_BLANK;
      dp_nxt  = 1'b1;
      fd_nxt  = 1'b0;
      if (state_nxt != ST_OFF) begin
         if (state_nxt == ST_ON) an_nxt = ~(AN_ONE << idx_nxt);
         seg_nxt = blank[idx_nxt] ? SEG_BLANK : dec_seg;
         dp_nxt  = ~act_nxt.dp_mask[idx_nxt];
         fd_nxt  = (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_OFF;
         cnt        <= '0;
         digit_idx  <= '0;
         pend       <= '0;
         pend_v     <= 1'b0;
         act        <= '0;
         an         <= AN_DARK;
         seg        <= SEG_BLANK;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         digit_idx  <= idx_nxt;
         pend       <= pend_nxt;
         pend_v     <= pend_v_nxt;
         act        <= act_nxt;
         an         <= an_nxt;
         seg        <= seg_nxt;
         dp         <= dp_nxt;
         frame_done <= fd_nxt;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for the display scanner: a time-indexed reference model
// queues the expected pins per cycle and a monitor compares after each edge.
module tb_seven_seg_scan_ctrl;

   localparam int N = 4;
   localparam int R = 8;
   localparam int G = 2;
   localparam int F = R * N;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_mask = '0;
   logic        lz_en = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [1:0]  digit_idx;
   logic        frame_done;

   seven_seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYCLES(G)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
      .dp_mask(dp_mask), .lz_en(lz_en), .an(an), .seg(seg), .dp(dp),
      .digit_idx(digit_idx), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic [1:0] idx;
      logic       fd;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   passed = 0;
   bit   done = 0;

   logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference: m_t counts cycles since scanning started; slot/digit/frame follow by division.
   bit          m_run = 0;
   int          m_t = 0;
   logic [15:0] s_val = '0, p_val = '0;
   logic [3:0]  s_dp = '0, p_dp = '0;
   bit          s_lz = 0, p_lz = 0, p_v = 0;

   task automatic tick();
      obs_t       e;
      bit         bnd, wasoff, blank;
      int         c, d;
      logic [3:0] onehot;
      logic [3:0] nibv;
      if (!rst_n) begin
         m_run = 0; m_t = 0;
         s_val = '0; s_dp = '0; s_lz = 0;
         p_val = '0; p_dp = '0; p_lz = 0; p_v = 0;
      end else begin
         bnd    = m_run && (m_t % F == F - 1);
         wasoff = !m_run;
         if (load && (wasoff || bnd)) begin
            s_val = value; s_dp = dp_mask; s_lz = lz_en; p_v = 0;
         end else if (load) begin
            p_val = value; p_dp = dp_mask; p_lz = lz_en; p_v = 1;
         end else if (bnd && p_v) begin
            s_val = p_val; s_dp = p_dp; s_lz = p_lz; p_v = 0;
         end
         if (!enable) begin m_run = 0; m_t = 0; end
         else if (!m_run) begin m_run = 1; m_t = 0; end
         else m_t++;
      end
      if (!m_run) begin
         e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, idx: 2'd0, fd: 1'b0};
      end else begin
         c      = m_t % R;
         d      = (m_t / R) % N;
         onehot = 4'b0001 << d;
         nibv   = 4'((s_val >> (4 * d)) & 16'hF);
         blank  = s_lz && (d != 0) && ((s_val >> (4 * d)) == 0);
         e.an   = (c >= G) ? ~onehot : 4'hF;
         e.seg  = blank ? 7'h7F : lut[nibv];
         e.dp   = ~s_dp[d];
         e.idx  = 2'(d);
         e.fd   = (m_t % F == F - 1);
      end
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      load = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] m, input bit lz);
      value = v; dp_mask = m; lz_en = lz; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic wait_phase(input int ph);
      load = 1'b0;
      for (int i = 0; i < 2 * F && !(m_run && (m_t % F == ph)); i++) tick();
   endtask

   initial begin : monitor
      obs_t e, got;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            if (!done) begin
               checks++;
               $display("FAIL queue: no expected entry at %0t", $time);
            end
         end else begin
            e   = exp_q.pop_front();
            got = '{an: an, seg: seg, dp: dp, idx: digit_idx, fd: frame_done};
            checks++;
            if (got !== e)
               $display("FAIL pins @%0t: got an=%b seg=%h dp=%b idx=%0d fd=%b, want an=%b seg=%h dp=%b idx=%0d fd=%b",
                        $time, got.an, got.seg, got.dp, got.idx, got.fd,
                        e.an, e.seg, e.dp, e.idx, e.fd);
            else
               passed++;
         end
      end
   end

   initial begin : stim
      int off_left;
      rst_n = 1'b0; enable = 1'b0;
      run(3);
      rst_n = 1'b1;
      run(2);
      enable = 1'b1;
      run(2 * F);
      wait_phase(13);
      do_load(16'h12AF, 4'b0000, 1'b0);
      run(2 * F);
      wait_phase(6);
      do_load(16'h0030, 4'b0010, 1'b1);
      run(2 * F);
      wait_phase(9);
      do_load(16'h1111, 4'b0001, 1'b0);
      run(5);
      do_load(16'h2222, 4'b1000, 1'b0);
      run(2 * F);
      wait_phase(F - 1);
      do_load(16'h0007, 4'b0100, 1'b1);
      run(F + 4);
      wait_phase(2 * R + 4);
      enable = 1'b0;
      run(3);
      enable = 1'b1;
      run(F + 3);
      wait_phase(5);
      do_load(16'h5678, 4'b1111, 1'b0);
      run(3);
      rst_n = 1'b0;
      run(2);
      rst_n = 1'b1;
      run(F + 2);
      enable = 1'b0;
      run(3);
      do_load(16'h9ABC, 4'b0101, 1'b0);
      run(2);
      enable = 1'b1;
      run(F + 2);
      do_load(16'h0000, 4'b0000, 1'b1);
      run(F + 2);
      off_left = 0;
      for (int i = 0; i < 2500; i++) begin
         rst_n = ($urandom_range(0, 799) != 0);
         if (off_left > 0) begin
            enable = 1'b0; off_left--;
         end else if ($urandom_range(0, 199) == 0) begin
            enable = 1'b0; off_left = $urandom_range(1, 12);
         end else begin
            enable = 1'b1;
         end
         load    = ($urandom_range(0, 11) == 0);
         value   = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         dp_mask = 4'($urandom);
         lz_en   = 1'($urandom);
         tick();
      end
      rst_n = 1'b1; load = 1'b0; enable = 1'b1;
      run(4);
      done = 1;
      #1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
